// File: rtl/mux_8t1_rr_arbiter.sv
// Round-robin arbiter driving one shared 8:1 n-bit data mux, with a bounded tenure per owner.
// Optional macro ARB_LOCK_EN: LOCK lets the current owner extend its tenure past MAX_HOLD.
module mux_8t1_rr_arbiter #(
    parameter int n        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [7:0]   REQ,
    input  logic         LOCK,
    input  logic [n-1:0] D0,
    input  logic [n-1:0] D1,
    input  logic [n-1:0] D2,
    input  logic [n-1:0] D3,
    input  logic [n-1:0] D4,
    input  logic [n-1:0] D5,
    input  logic [n-1:0] D6,
    input  logic [n-1:0] D7,
    output logic [7:0]   GNT,
    output logic [2:0]   SEL,
    output logic         VALID,
    output logic [n-1:0] D_OUT
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] hold_cnt;
    logic [2:0]    last;
    logic [2:0]    winner;
    logic          lock_ext;
    logic          stay;

`ifdef ARB_LOCK_EN
    assign lock_ext = LOCK;
`else
    logic unused_lock;
    assign unused_lock = LOCK;
    assign lock_ext    = 1'b0;
`endif

    // Search starts one past the previous owner, so an owner that just expired ranks last.
    always_comb begin
        logic found;
        logic [2:0] idx;
        // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = last + 3'(i);
            if (!found && REQ[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign stay = REQ[SEL] && ((hold_cnt != HOLD_MAX) || lock_ext);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            GNT      <= '0;
            SEL      <= '0;
            VALID    <= 1'b0;
            hold_cnt <= '0;
            last     <= 3'd7;
        end else begin
            case (state)
                GRANT: begin
                    if (stay) begin
                        if (hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        state    <= GAP;
                        GNT      <= '0;
                        VALID    <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                // IDLE and the single GAP cycle share the same arbitration rules.
                default: begin
                    if (|REQ) begin
                        state    <= GRANT;
                        SEL      <= winner;
                        GNT      <= 8'b1 << winner;
                        VALID    <= 1'b1;
                        last     <= winner;
                        hold_cnt <= CW'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        D_OUT = '0;
        if (VALID) begin
            case (SEL)
                3'd0:    D_OUT = D0;
                3'd1:    D_OUT = D1;
                3'd2:    D_OUT = D2;
                3'd3:    D_OUT = D3;
                3'd4:    D_OUT = D4;
                3'd5:    D_OUT = D5;
                3'd6:    D_OUT = D6;
                default: D_OUT = D7;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_8t1_rr_arbiter.sv
// Directed self-checking bench: main instance at MAX_HOLD=16, second instance at MAX_HOLD=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge before new inputs.
module tb_mux_8t1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic       lock = 1'b0;
    logic [7:0] d0 = 8'h10, d1 = 8'h21, d2 = 8'h32, d3 = 8'h43;
    logic [7:0] d4 = 8'hA5, d5 = 8'h5C, d6 = 8'h6D, d7 = 8'h7E;

    logic [7:0] gnt_a, gnt_b, dout_a, dout_b;
    logic [2:0] sel_a, sel_b;
    logic       valid_a, valid_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_8t1_rr_arbiter #(.n(8), .MAX_HOLD(16)) dut_a (
        .CLK(clk), .RST(rst), .REQ(req_a), .LOCK(lock),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5), .D6(d6), .D7(d7),
        .GNT(gnt_a), .SEL(sel_a), .VALID(valid_a), .D_OUT(dout_a)
    );

    mux_8t1_rr_arbiter #(.n(8), .MAX_HOLD(2)) dut_b (
        .CLK(clk), .RST(rst), .REQ(req_b), .LOCK(1'b0),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5), .D6(d6), .D7(d7),
        .GNT(gnt_b), .SEL(sel_b), .VALID(valid_b), .D_OUT(dout_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_a = '0;
        req_b = '0;
        lock  = 1'b0;
        rst   = 1'b1;
        cyc();
        rst   = 1'b0;
    endtask

    initial begin
        // Reset state and idle with no requests.
        cyc();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc();
            check("idle_valid", valid_a, 0);
            check("idle_sel",   sel_a,   0);
            check("idle_gnt",   gnt_a,   0);
            check("idle_dout",  dout_a,  0);
        end

        // REQ=0x90 from reset: requester 4 wins first.
        req_a = 8'h90;
        cyc();
        check("t2_gnt",   gnt_a,   8'h10);
        check("t2_sel",   sel_a,   4);
        check("t2_valid", valid_a, 1);
        check("t2_dout",  dout_a,  8'hA5);

        // Owner 3 drops after three grant cycles; one GAP then 4 wins.
        do_reset();
        req_a = 8'h18;
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("t4_gnt3", gnt_a, 8'h08);
            check("t4_dout3", dout_a, 8'h43);
        end
        req_a = 8'h10;
        cyc();
        check("t4_gap_valid", valid_a, 0);
        check("t4_gap_gnt",   gnt_a,   0);
        check("t4_gap_sel",   sel_a,   3);
        check("t4_gap_dout",  dout_a,  0);
        cyc();
        check("t4_next_gnt", gnt_a, 8'h10);
        check("t4_next_sel", sel_a, 4);

        // Asynchronous reset mid-grant with owner 5.
        do_reset();
        req_a = 8'h20;
        cyc();
        check("t1_pre_sel",  sel_a,  5);
        check("t1_pre_dout", dout_a, 8'h5C);
        cyc();
        #2 rst = 1'b1;
        #1;
        check("t1_rst_gnt",   gnt_a,   0);
        check("t1_rst_valid", valid_a, 0);
        check("t1_rst_dout",  dout_a,  0);
        cyc();
        rst   = 1'b0;
        req_a = 8'h21;
        cyc();
        check("t1_after_gnt", gnt_a, 8'h01);

        // MAX_HOLD=2 with all requesting: 2 grant cycles, 1 gap, rotating and wrapping 7->0.
        do_reset();
        req_b = 8'hFF;
        for (int c = 0; c < 27; c++) begin
            logic [7:0] exp_gnt;
            cyc();
            exp_gnt = ((c % 3) < 2) ? (8'h01 << ((c / 3) % 8)) : 8'h00;
            check("t3_gnt", gnt_b, exp_gnt);
        end

        // Owner 2 holds REQ with LOCK for 40 cycles at MAX_HOLD=16.
        do_reset();
        lock  = 1'b1;
        req_a = 8'h04;
        for (int c = 0; c < 40; c++) begin
            logic [7:0] exp_gnt;
            cyc();
`ifdef ARB_LOCK_EN
            exp_gnt = 8'h04;
`else
            exp_gnt = ((c % 17) == 16) ? 8'h00 : 8'h04;
`endif
            check("t5_gnt", gnt_a, exp_gnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
